main_ctrl_pipe: RTL and testbench
=================================

Name: main_ctrl_pipe

Overview:
- Next-generation main control unit for the 5-stage RV32 pipeline.
- Decodes op/funct3/funct7 in the decode stage and registers the full control bundle into the decode/execute (D/E) boundary.
- Adds a valid bit, stall/flush handling, illegal-opcode flagging and deterministic (no X) outputs.
- Optionally adds a multi-cycle M-extension sequencer that back-pressures the front end.

Parameters:
- DIV_CYCLES, 32, total execute cycles for DIV/DIVU/REM/REMU (legal range 2..64).
- MUL_CYCLES, 2, total execute cycles for MUL/MULH/MULHSU/MULHU (legal range 1..64; 1 = single-cycle, no stall).
- CNT_W, $clog2(64)+1, sequencer counter width.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- valid_d  in  1  instruction present in decode
- op_d  in  7  instr[6:0]
- funct3_d  in  3  instr[14:12]
- funct7_d  in  7  instr[31:25]
- stall_e  in  1  hold D/E register (from hazard unit)
- flush_e  in  1  bubble D/E register (branch/jump taken)
- ctrl_e  out  15  registered bundle {RegWrite, ImmSrc[2:0], ALUSrcA, ALUSrcB[1:0], MemWrite, ResultSrc[1:0], Branch, ALUOp[1:0], Jump, PCJalSrc}
- valid_e  out  1  D/E register holds a real instruction
- illegal_e  out  1  captured opcode not in the decode table
- md_e  out  2  00 none, 01 mul, 10 div/rem
- md_busy  out  1  sequencer stall request to fetch/decode/hazard unit
- md_done  out  1  one-cycle pulse on the last execute cycle of an M op

Behaviour:
- Reset (async, rst_n=0): ctrl_e=0, valid_e=0, illegal_e=0, md_e=00, md_busy=0, md_done=0, FSM=IDLE, counter=0.
- Decode table (comb, bundle field order as in ctrl_e):
  - 0000011 lw: 1_000_0_01_0_01_0_00_0_0
  - 0010011 I-ALU: 1_000_0_01_0_00_0_10_0_0
  - 0010111 auipc: 1_100_1_10_0_00_0_00_0_0
  - 0100011 store: 0_001_0_01_1_00_0_00_0_0
  - 0110011 R: 1_000_0_00_0_00_0_10_0_0
  - 0110111 lui: 1_100_1_01_0_00_0_00_0_0
  - 1100011 branch: 0_010_0_00_0_00_1_01_0_0
  - 1101111 jal: 1_011_0_00_0_10_0_00_1_0
  - 1100111 jalr: 1_000_0_01_0_10_0_00_1_1
  - 0000000: all zero, legal.
  - Any other op: all zero, illegal=1.
  - All former don't-care fields are driven 0.
- Latency: 1 cycle from decode inputs to D/E outputs.
- Register update priority per clock edge: flush_e > (stall_e | md_busy) hold > load.
  - Load: valid_e<=valid_d; ctrl_e/illegal_e/md_e <= decode when valid_d, else 0.
  - Flush or invalid load: bundle forced to 0, valid_e=0, illegal_e=0, md_e=00.
- illegal_e is only ever 1 when valid_e=1.
- Sequencer FSM, states IDLE and BUSY:
  - IDLE -> BUSY when a div/rem loads (or a mul with MUL_CYCLES>1). Counter<=N-2, where N is the op's cycle count.
  - In BUSY: md_busy=1 (combinational from state). The D/E register holds, and upstream must hold its instruction.
  - BUSY: counter decrements each cycle. At counter==0: md_done=1 for that cycle, md_busy deasserts, next state IDLE, and the D/E register accepts new input on the following edge.
  - Net effect: the M op occupies E for exactly N cycles.
  - MUL_CYCLES=1: no BUSY state entry; md_done pulses in the load+1 cycle.
- Simultaneous events:
  - flush_e in BUSY aborts: next state IDLE, counter=0, md_done not pulsed, register bubbled.
  - stall_e in BUSY does not freeze the counter.
  - stall_e and flush_e together: flush wins.
- Reset mid-BUSY: immediate return to the reset state; no md_done.

Optional Feature:
- Macro MAIN_CTRL_MEXT_EN.
- Defined: R-type with funct7=0000001 decodes as an M op (funct3[2]=1 → div, else mul). ctrl_e uses the R-type row; md_e is set; the sequencer is present.
- Undefined: funct7=0000001 is a plain R-type; md_e, md_busy and md_done are tied 0; FSM and counter are not built.

Decomposition:
- Package main_ctrl_pkg holds:
  - Opcode localparams (OP_LOAD, OP_IMM, OP_AUIPC, OP_STORE, OP_R, OP_LUI, OP_BRANCH, OP_JAL, OP_JALR).
  - Packed struct ctrl_t holding the 15-bit bundle.
  - Enum md_t {MD_NONE, MD_MUL, MD_DIV}.
  - Enum md_state_t {IDLE, BUSY}.
- One sub-module, md_seq: FSM, counter and the md_busy/md_done outputs, instantiated only under MAIN_CTRL_MEXT_EN.
- Decode table is a comb function in the package.

Test Plan:
- Reset release, then valid_d=1 with op_d=0000011 → next cycle valid_e=1, ctrl_e=15'b1_000_0_01_0_01_0_00_0_0, illegal_e=0.
- op_d=1110000, valid_d=1 → ctrl_e=0, valid_e=1, illegal_e=1. Same op with valid_d=0 → illegal_e=0.
- jal loaded with flush_e=1 on the same edge → valid_e=0, ctrl_e=0. stall_e=1 for 3 cycles → outputs frozen at their prior value.
- MEXT_EN, DIV_CYCLES=32: DIV loads → md_busy=1 for cycles 1..31, md_done=1 in cycle 32; the next instruction loads at the cycle-32 edge.
- MEXT_EN, MUL in BUSY, flush_e=1 in cycle 1 → md_busy=0 the next cycle, no md_done, valid_e=0.
- rst_n pulsed low asynchronously mid-DIV → all outputs 0 immediately, FSM IDLE after release.

Source files
------------

// File: rtl/main_ctrl_pkg.sv
// Shared types, opcodes and the combinational decode table for main_ctrl_pipe.
// Build option: MAIN_CTRL_MEXT_EN adds the M-extension decode helper.
package main_ctrl_pkg;

  localparam logic [6:0] OP_NONE   = 7'b0000000;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // funct7 value that selects the M extension inside the R-type opcode
  localparam logic [6:0] F7_MEXT   = 7'b0000001;

  typedef struct packed {
    logic       reg_write;
    logic [2:0] imm_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic [1:0] alu_op;
    logic       jump;
    logic       pc_jal_src;
  } ctrl_t;

  typedef enum logic [1:0] {
    MD_NONE = 2'b00,
    MD_MUL  = 2'b01,
    MD_DIV  = 2'b10
  } md_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  typedef struct packed {
    ctrl_t ctrl;
    logic  illegal;
  } dec_t;

  // Opcode -> control bundle; unknown opcodes give an all-zero bundle and flag illegal.
  // Literal layout follows the ctrl_t field order.
  function automatic dec_t decode(input logic [6:0] op);
    dec_t d;
    d = '0;
    case (op)
      OP_LOAD:   d.ctrl = ctrl_t'(15'b1_000_0_01_0_01_0_00_0_0);
      OP_IMM:    d.ctrl = ctrl_t'(15'b1_000_0_01_0_00_0_10_0_0);
      OP_AUIPC:  d.ctrl = ctrl_t'(15'b1_100_1_10_0_00_0_00_0_0);
      OP_STORE:  d.ctrl = ctrl_t'(15'b0_001_0_01_1_00_0_00_0_0);
      OP_R:      d.ctrl = ctrl_t'(15'b1_000_0_00_0_00_0_10_0_0);
      OP_LUI:    d.ctrl = ctrl_t'(15'b1_100_1_01_0_00_0_00_0_0);
      OP_BRANCH: d.ctrl = ctrl_t'(15'b0_010_0_00_0_00_1_01_0_0);
      OP_JAL:    d.ctrl = ctrl_t'(15'b1_011_0_00_0_10_0_00_1_0);
      OP_JALR:   d.ctrl = ctrl_t'(15'b1_000_0_01_0_10_0_00_1_1);
      OP_NONE:   d.ctrl = '0;
      default:   d.illegal = 1'b1;
    endcase
    return d;
  endfunction

`ifdef MAIN_CTRL_MEXT_EN
  // R-type with the M funct7 is a multiply or a divide/remainder (funct3[2] picks div).
  function automatic md_t md_decode(input logic [6:0] op, input logic div_sel,
                                    input logic [6:0] funct7);
    if (op == OP_R && funct7 == F7_MEXT) begin
      return div_sel ? MD_DIV : MD_MUL;
    end
    return MD_NONE;
  endfunction
`endif

endpackage

// File: rtl/main_ctrl_pipe_md_seq.sv
// Multi-cycle M-op sequencer: keeps an M op in execute for exactly its cycle count
// by requesting a stall (busy_o) and pulsing done_o on the op's last execute cycle.
module md_seq
  import main_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int MUL_CYCLES = 2,
  parameter int CNT_W      = $clog2(64) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  md_t  md_i,
  input  logic flush_i,
  output logic busy_o,
  output logic done_o
);

  // The load edge is cycle 1 and the final (done) cycle is spent back in IDLE,
  // so BUSY lasts N-1 cycles: the counter starts at N-2 and exits at zero.
  localparam int DIV_LOAD = DIV_CYCLES - 2;
  localparam int MUL_LOAD = (MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0;

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // Next-state logic: start from IDLE, count down in BUSY, flush aborts silently
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (md_i == MD_DIV) begin
            state_d = BUSY;
            cnt_d   = CNT_W'(DIV_LOAD);
          end else if (MUL_CYCLES > 1) begin
            state_d = BUSY;
            cnt_d   = CNT_W'(MUL_LOAD);
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      BUSY: begin
        if (flush_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and done-pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q == BUSY);
  assign done_o = done_q;

endmodule

// File: rtl/main_ctrl_pipe.sv
// Main control unit: decodes op/funct3/funct7 and registers the control bundle
// into the D/E boundary with valid, stall/flush and illegal-opcode handling.
// Build option: MAIN_CTRL_MEXT_EN enables M-op decode and the md_seq sequencer.
module main_ctrl_pipe
  import main_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int MUL_CYCLES = 2,
  parameter int CNT_W      = $clog2(64) + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_d,
  input  logic [6:0]  op_d,
  input  logic [2:0]  funct3_d,
  input  logic [6:0]  funct7_d,
  input  logic        stall_e,
  input  logic        flush_e,
  output logic [14:0] ctrl_e,
  output logic        valid_e,
  output logic        illegal_e,
  output logic [1:0]  md_e,
  output logic        md_busy,
  output logic        md_done
);

  if (DIV_CYCLES < 2 || DIV_CYCLES > 64) begin : g_bad_div
    $error("DIV_CYCLES must be in 2..64");
  end
  if (MUL_CYCLES < 1 || MUL_CYCLES > 64) begin : g_bad_mul
    $error("MUL_CYCLES must be in 1..64");
  end
  if (CNT_W < 7) begin : g_bad_cnt
    $error("CNT_W too narrow for 64-cycle ops");
  end

  dec_t  dec;
  ctrl_t ctrl_q;
  logic  valid_q;
  logic  illegal_q;
  logic  hold;
  logic  load;

  assign dec = decode(op_d);

`ifdef MAIN_CTRL_MEXT_EN
  md_t  dec_md;
  md_t  md_q;
  logic seq_busy;
  logic seq_done;
  logic unused_funct3;

  assign dec_md        = md_decode(op_d, funct3_d[2], funct7_d);
  assign unused_funct3 = ^funct3_d[1:0];
  assign hold          = stall_e | seq_busy;

  md_seq #(
    .DIV_CYCLES (DIV_CYCLES),
    .MUL_CYCLES (MUL_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (load & valid_d & (dec_md != MD_NONE)),
    .md_i    (dec_md),
    .flush_i (flush_e),
    .busy_o  (seq_busy),
    .done_o  (seq_done)
  );

  // M-op class follows the same flush > hold > load priority as the bundle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_q <= MD_NONE;
    end else if (flush_e) begin
      md_q <= MD_NONE;
    end else if (load) begin
      md_q <= valid_d ? dec_md : MD_NONE;
    end
  end

  assign md_e    = md_q;
  assign md_busy = seq_busy;
  assign md_done = seq_done;
`else
  logic unused_funct;

  assign unused_funct = ^{funct3_d, funct7_d};
  assign hold         = stall_e;
  assign md_e         = 2'b00;
  assign md_busy      = 1'b0;
  assign md_done      = 1'b0;
`endif

  assign load = ~flush_e & ~hold;

  // D/E register: flush bubbles, hold freezes, otherwise capture decode (zeroed when invalid)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (flush_e) begin
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (load) begin
      ctrl_q    <= valid_d ? dec.ctrl : '0;
      valid_q   <= valid_d;
      illegal_q <= valid_d & dec.illegal;
    end
  end

  assign ctrl_e    = ctrl_q;
  assign valid_e   = valid_q;
  assign illegal_e = illegal_q;

endmodule

// File: tb/tb_main_ctrl_pipe.sv
// Self-checking bench for main_ctrl_pipe: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_main_ctrl_pipe;

  localparam int DIV_N = 32;
  localparam int MUL_N = 2;
`ifdef MAIN_CTRL_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_d = 1'b0;
  logic [6:0]  op_d = '0;
  logic [2:0]  funct3_d = '0;
  logic [6:0]  funct7_d = '0;
  logic        stall_e = 1'b0;
  logic        flush_e = 1'b0;
  logic [14:0] ctrl_e;
  logic        valid_e;
  logic        illegal_e;
  logic [1:0]  md_e;
  logic        md_busy;
  logic        md_done;

  main_ctrl_pipe #(
    .DIV_CYCLES (DIV_N),
    .MUL_CYCLES (MUL_N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_d   (valid_d),
    .op_d      (op_d),
    .funct3_d  (funct3_d),
    .funct7_d  (funct7_d),
    .stall_e   (stall_e),
    .flush_e   (flush_e),
    .ctrl_e    (ctrl_e),
    .valid_e   (valid_e),
    .illegal_e (illegal_e),
    .md_e      (md_e),
    .md_busy   (md_busy),
    .md_done   (md_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: D/E contents plus position k (1..n) of an M op within its n execute cycles
  logic [14:0] m_ctrl;
  logic        m_valid;
  logic        m_ill;
  logic [1:0]  m_md;
  int          m_k;
  int          m_n;

  logic [6:0] ops [12] = '{7'b0000011, 7'b0010011, 7'b0010111, 7'b0100011, 7'b0110011,
                           7'b0110111, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0000000,
                           7'b0110011, 7'b1110000};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // {illegal, bundle} straight from the opcode table
  function automatic logic [15:0] ref_dec(input logic [6:0] op);
    case (op)
      7'b0000011: return {1'b0, 15'b1_000_0_01_0_01_0_00_0_0};
      7'b0010011: return {1'b0, 15'b1_000_0_01_0_00_0_10_0_0};
      7'b0010111: return {1'b0, 15'b1_100_1_10_0_00_0_00_0_0};
      7'b0100011: return {1'b0, 15'b0_001_0_01_1_00_0_00_0_0};
      7'b0110011: return {1'b0, 15'b1_000_0_00_0_00_0_10_0_0};
      7'b0110111: return {1'b0, 15'b1_100_1_01_0_00_0_00_0_0};
      7'b1100011: return {1'b0, 15'b0_010_0_00_0_00_1_01_0_0};
      7'b1101111: return {1'b0, 15'b1_011_0_00_0_10_0_00_1_0};
      7'b1100111: return {1'b0, 15'b1_000_0_01_0_10_0_00_1_1};
      7'b0000000: return 16'h0000;
      default:    return 16'h8000;
    endcase
  endfunction

  function automatic logic [1:0] ref_md(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7);
    if (MEXT && op == 7'b0110011 && f7 == 7'b0000001) return f3[2] ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_ctrl = '0; m_valid = 1'b0; m_ill = 1'b0; m_md = 2'b00; m_k = 0; m_n = 0;
  endtask

  // One clock edge of the model, using the inputs that were stable before the edge
  task automatic model_step();
    bit          busy_now;
    logic [15:0] r;
    busy_now = (m_k >= 1) && (m_k < m_n);
    r = ref_dec(op_d);
    if (flush_e) begin
      model_reset();
    end else if (stall_e || busy_now) begin
      m_k = busy_now ? m_k + 1 : 0;
    end else begin
      m_valid = valid_d;
      m_ctrl  = valid_d ? r[14:0] : 15'd0;
      m_ill   = valid_d & r[15];
      m_md    = valid_d ? ref_md(op_d, funct3_d, funct7_d) : 2'b00;
      m_k     = (m_md != 2'b00) ? 1 : 0;
      m_n     = (m_md == 2'b10) ? DIV_N : MUL_N;
    end
  endtask

  task automatic check_all();
    chk("ctrl_e",    32'(ctrl_e),    32'(m_ctrl));
    chk("valid_e",   32'(valid_e),   32'(m_valid));
    chk("illegal_e", 32'(illegal_e), 32'(m_ill));
    chk("md_e",      32'(md_e),      32'(m_md));
    chk("md_busy",   32'(md_busy),   32'((m_k >= 1) && (m_k < m_n)));
    chk("md_done",   32'(md_done),   32'((m_k >= 1) && (m_k == m_n)));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic st, input logic fl);
    valid_d = v; op_d = op; funct3_d = f3; funct7_d = f7; stall_e = st; flush_e = fl;
  endtask

  initial begin
    model_reset();
    tick();
    tick();
    chk("rst_ctrl",  32'(ctrl_e),  32'd0);
    chk("rst_valid", 32'(valid_e), 32'd0);
    chk("rst_busy",  32'(md_busy), 32'd0);
    rst_n = 1'b1;

    // lw captured one cycle later
    drive(1'b1, 7'b0000011, 3'd2, 7'd0, 1'b0, 1'b0);
    tick();
    chk("lw_ctrl", 32'(ctrl_e), 32'(15'b1_000_0_01_0_01_0_00_0_0));

    // illegal opcode valid / invalid
    drive(1'b1, 7'b1110000, 3'd0, 7'd0, 1'b0, 1'b0);
    tick();
    chk("ill_flag", 32'(illegal_e), 32'd1);
    drive(1'b0, 7'b1110000, 3'd0, 7'd0, 1'b0, 1'b0);
    tick();
    chk("ill_novalid", 32'(illegal_e), 32'd0);

    // jal with simultaneous flush, then lui held by a 3-cycle stall
    drive(1'b1, 7'b1101111, 3'd0, 7'd0, 1'b0, 1'b1);
    tick();
    chk("flush_valid", 32'(valid_e), 32'd0);
    drive(1'b1, 7'b0110111, 3'd0, 7'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 7'b0100011, 3'd0, 7'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("stall_ctrl", 32'(ctrl_e), 32'(15'b1_100_1_01_0_00_0_00_0_0));

    // DIV occupies execute for DIV_N cycles, then the waiting addi loads
    drive(1'b1, 7'b0110011, 3'd4, 7'd1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 7'b0010011, 3'd0, 7'd0, 1'b0, 1'b0);
    for (int i = 0; i < DIV_N; i++) tick();

    // MUL aborted by a flush in its first cycle
    drive(1'b1, 7'b0110011, 3'd0, 7'd1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 7'b0000000, 3'd0, 7'd0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 7'b0000000, 3'd0, 7'd0, 1'b0, 1'b0);
    tick();

    // asynchronous reset in the middle of a DIV
    drive(1'b1, 7'b0110011, 3'd5, 7'd1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 7'b0000000, 3'd0, 7'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_ctrl",  32'(ctrl_e),  32'd0);
    chk("arst_valid", 32'(valid_e), 32'd0);
    chk("arst_md",    32'(md_e),    32'd0);
    chk("arst_busy",  32'(md_busy), 32'd0);
    chk("arst_done",  32'(md_done), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // random traffic
    for (int i = 0; i < 800; i++) begin
      valid_d  = ($urandom_range(0, 9) < 8);
      op_d     = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 11)];
      funct3_d = 3'($urandom);
      funct7_d = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'b0000001;
      stall_e  = ($urandom_range(0, 99) < 12);
      flush_e  = ($urandom_range(0, 99) < 4);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
